lagarto_l15_arbiter: RTL

Shares the single per-tile L1.5 request port between the Lagarto fetch (icache fill) requester and the load/store (dcache) requester. Grants are round-robin. The block holds each granted request stable until the L1.5 acknowledges it, and counts outstanding transactions per requester. Returns are routed back by thread id. A drain handshake lets reset and flush logic stop new traffic and wait for quiescence.

---
 rtl/lagarto_l15_arb_pkg.sv | 29 ++
 rtl/lagarto_l15_arbiter_rr.sv | 31 +++
 rtl/lagarto_l15_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lagarto_l15_arb_pkg.sv
// Shared types for the Lagarto L1.5 request-port arbiter: FSM states,
// L1.5 request-type codes and the latched request record.
package lagarto_l15_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam logic [4:0] L15_LOAD  = 5'b00000;
  localparam logic [4:0] L15_STORE = 5'b00001;
  localparam logic [4:0] L15_IFILL = 5'b10000;

  // Native L1.5 field widths; the top casts port widths to and from these.
  localparam int L15_ADDR_W = 40;
  localparam int L15_DATA_W = 64;

  typedef struct packed {
    logic [4:0]            rtype;
    logic [L15_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [L15_DATA_W-1:0] data;
  } req_fields_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lagarto_l15_arbiter_rr.sv
// Round-robin pick: first eligible requester at or after ptr_i, wrapping.
module lagarto_rr_arbiter
  import lagarto_l15_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    logic found;
    int   k;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = (int'(ptr_i) + off) % NUM_REQ;
      if (!found && elig_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/lagarto_l15_arbiter.sv
// Shares the per-tile L1.5 request port between icache (0) and dcache (1):
// round-robin grant, hold until ack, per-requester outstanding counters.
module lagarto_l15_arbiter
  import lagarto_l15_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADDR_W  = 40,
  parameter  int DATA_W  = 64,
  parameter  int RTRN_W  = 128,
  parameter  int MAX_OUT = 4,
  localparam int IDX_W   = idx_w(NUM_REQ),
  localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_l,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ-1:0][4:0]          req_type_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][2:0]          req_size_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data_i,
  output logic                             l15_val_o,
  input  logic                             l15_ack_i,
  output logic [4:0]                       l15_type_o,
  output logic [ADDR_W-1:0]                l15_addr_o,
  output logic [2:0]                       l15_size_o,
  output logic [DATA_W-1:0]                l15_data_o,
  output logic [IDX_W-1:0]                 l15_threadid_o,
  input  logic                             l15_rtrn_val_i,
  input  logic [IDX_W-1:0]                 l15_rtrn_threadid_i,
  input  logic [RTRN_W-1:0]                l15_rtrn_data_i,
  output logic [NUM_REQ-1:0]               rtrn_val_o,
  output logic [RTRN_W-1:0]                rtrn_data_o,
  input  logic                             drain_i,
  output logic                             drained_o,
  output logic                             err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

  arb_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                 ptr_q, ptr_d, tid_q, tid_d, win;
  req_fields_t                      fld_q, fld_d;
  logic [NUM_REQ-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic                             err_q, err_d;
  logic [NUM_REQ-1:0]               elig, gnt;
  logic                             ack;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid_i[i] && (cnt_q[i] < CNT_MAX) && !drain_i;
  end

  lagarto_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .elig_i (elig),
    .ptr_i  (ptr_q),
    .gnt_o  (gnt),
    .idx_o  (win)
  );

  assign ack         = (state_q == ISSUE) && l15_ack_i;
  assign req_ready_o = (state_q == IDLE) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tid_d   = tid_q;
    fld_d   = fld_q;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d    = ISSUE;
          tid_d      = win;
          fld_d.rtype = req_type_i[win];
          fld_d.addr = L15_ADDR_W'(req_addr_i[win]);
          fld_d.size = req_size_i[win];
          fld_d.data = L15_DATA_W'(req_data_i[win]);
        end
      end
      ISSUE: begin
        if (l15_ack_i) begin
          state_d = IDLE;
          ptr_d   = (tid_q == IDX_W'(NUM_REQ - 1)) ? '0 : tid_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ack and return for the same owner cancel; a return with nothing
  // outstanding (and no ack landing) is flagged instead of underflowing.
  always_comb begin
    logic hit, inc;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rtrn_val_o = '0;
    hit        = 1'b0;
    inc        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      hit           = l15_rtrn_val_i && (l15_rtrn_threadid_i == IDX_W'(k));
      inc           = ack && (tid_q == IDX_W'(k));
      rtrn_val_o[k] = hit;
      if (inc && !hit)
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      else if (hit && !inc) begin
        if (cnt_q[k] == '0) err_d = 1'b1;
        else                cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tid_q   <= '0;
      fld_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tid_q   <= tid_d;
      fld_q   <= fld_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign l15_val_o      = (state_q == ISSUE);
  assign l15_type_o     = fld_q.rtype;
  assign l15_addr_o     = ADDR_W'(fld_q.addr);
  assign l15_size_o     = fld_q.size;
  assign l15_data_o     = DATA_W'(fld_q.data);
  assign l15_threadid_o = tid_q;
  assign rtrn_data_o    = l15_rtrn_data_i;
  assign drained_o      = (state_q == IDLE) && (cnt_q == '0);
  assign err_o          = err_q;

endmodule
